// File: rtl/uart.sv
// uart: FIFO-buffered UART with oversampled receiver, shared baud tick and optional RTS/CTS flow control
`timescale 1ns/1ps
module uart #(
  parameter int DataLength      = 8,
  parameter int FifoDepth       = 8,
  parameter int OverSample      = 8,
  parameter int BaudRate        = 115200,
  parameter int SystemClockFreq = 133_000_000,
  parameter int FlowControl     = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [7:0]            i_ctrl,
  output logic [7:0]            o_status,
  input  logic [DataLength-1:0] i_tx_data,
  output logic [DataLength-1:0] o_rx_data,
  input  logic                  i_tx_req,
  input  logic                  i_rx_req,
  output logic                  o_rx_rdy,
  output logic                  o_tx_rdy,
  input  logic                  i_rx,
  output logic                  o_tx,
  input  logic                  i_cts,
  output logic                  o_rts
);
  localparam int Div = SystemClockFreq / (BaudRate * OverSample);
  localparam int BW  = $clog2(Div + 1);
  localparam int TW  = $clog2(OverSample + 1);
  localparam int NW  = $clog2(DataLength + 1);
  localparam int AW  = $clog2(FifoDepth);
  localparam int CW  = $clog2(FifoDepth + 1);
  localparam logic [TW-1:0] Os      = TW'(OverSample);
  localparam logic [TW-1:0] OsM1    = TW'(OverSample - 1);
  localparam logic [TW-1:0] HalfM1  = TW'(OverSample / 2 - 1);
  localparam logic [NW-1:0] LastBit = NW'(DataLength - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [1:0]            w_push, w_pop, w_full, w_empty;
  logic [DataLength-1:0] w_fin  [2];
  logic [DataLength-1:0] w_fout [2];
  logic [CW-1:0]         w_fcnt [2];
  logic                  w_unused;

  // index 0 is the TX FIFO, index 1 the RX FIFO; both show-ahead with a zero head when empty
  for (genvar f = 0; f < 2; f++) begin : g_fifo
    logic [DataLength-1:0] r_mem [FifoDepth];
    logic [AW-1:0]         r_wp, r_rp;
    logic [CW-1:0]         r_cnt;
    logic                  w_rd, w_wr;
    assign w_rd       = w_pop[f] && !w_empty[f];
    assign w_wr       = w_push[f] && (!w_full[f] || w_rd);
    assign w_empty[f] = r_cnt == '0;
    assign w_full[f]  = r_cnt == CW'(FifoDepth);
    assign w_fout[f]  = w_empty[f] ? '0 : r_mem[r_rp];
    assign w_fcnt[f]  = r_cnt;
    always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
      end else begin
        r_wp  <= r_wp + AW'(w_wr);
        r_rp  <= r_rp + AW'(w_rd);
        r_cnt <= r_cnt + CW'(w_wr) - CW'(w_rd);
      end
    always_ff @(posedge i_clk) if (w_wr) r_mem[r_wp] <= w_fin[f];
  end

  logic [BW-1:0] r_baud;
  logic          w_tick;
  assign w_tick = r_baud == BW'(Div - 1);

  state_t                r_tx_st, w_tx_st;
  logic [TW-1:0]         r_tx_cnt, w_tx_cnt;
  logic [NW-1:0]         r_tx_bit, w_tx_bit;
  logic [DataLength-1:0] r_tx_sh, w_tx_sh;
  logic                  r_tx, w_tx, w_tx_pop, w_tx_go;

  // START idles high (count 0) until the first tick so every bit spans exactly OverSample ticks
  always_comb begin
    w_tx_st  = r_tx_st;
    w_tx_cnt = r_tx_cnt;
    w_tx_bit = r_tx_bit;
    w_tx_sh  = r_tx_sh;
    w_tx_pop = 1'b0;
    w_tx_go  = !w_empty[0] && (i_cts || FlowControl == 0);
    case (r_tx_st)
      IDLE: if (w_tx_go) begin
        w_tx_st  = START;
        w_tx_cnt = '0;
        w_tx_pop = 1'b1;
        w_tx_sh  = w_fout[0];
      end
      START: if (w_tick) begin
        w_tx_cnt = r_tx_cnt + 1'b1;
        if (r_tx_cnt == Os) begin
          w_tx_st  = DATA;
          w_tx_cnt = TW'(1);
          w_tx_bit = '0;
        end
      end
      DATA: if (w_tick) begin
        w_tx_cnt = r_tx_cnt + 1'b1;
        if (r_tx_cnt == Os) begin
          w_tx_cnt = TW'(1);
          w_tx_sh  = r_tx_sh >> 1;
          w_tx_bit = r_tx_bit + 1'b1;
          w_tx_st  = r_tx_bit == LastBit ? STOP : DATA;
        end
      end
      default: if (w_tick) begin
        w_tx_cnt = r_tx_cnt + 1'b1;
        if (r_tx_cnt == Os) begin
          w_tx_cnt = TW'(1);
          w_tx_st  = w_tx_go ? START : IDLE;
          w_tx_pop = w_tx_go;
          w_tx_sh  = w_fout[0];
        end
      end
    endcase
    w_tx = w_tx_st == START ? w_tx_cnt == '0 : w_tx_st == DATA ? w_tx_sh[0] : 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_tx_st  <= IDLE;
      r_tx_cnt <= '0;
      r_tx_bit <= '0;
      r_tx_sh  <= '0;
      r_tx     <= 1'b1;
    end else begin
      r_tx_st  <= w_tx_st;
      r_tx_cnt <= w_tx_cnt;
      r_tx_bit <= w_tx_bit;
      r_tx_sh  <= w_tx_sh;
      r_tx     <= w_tx;
    end

  state_t                r_rx_st, w_rx_st;
  logic [TW-1:0]         r_rx_cnt, w_rx_cnt;
  logic [NW-1:0]         r_rx_bit, w_rx_bit;
  logic [DataLength-1:0] r_rx_sh, w_rx_sh;
  logic [1:0]            r_sync;
  logic                  r_rx_brk, w_rx_brk, w_rx_push, w_rxs;
  assign w_rxs = r_sync[1];

  // r_rx_brk holds STOP after a framing error until the line returns high
  always_comb begin
    w_rx_st   = r_rx_st;
    w_rx_cnt  = r_rx_cnt;
    w_rx_bit  = r_rx_bit;
    w_rx_sh   = r_rx_sh;
    w_rx_brk  = r_rx_brk;
    w_rx_push = 1'b0;
    case (r_rx_st)
      IDLE: if (!w_rxs) begin
        w_rx_st  = START;
        w_rx_cnt = '0;
      end
      START: if (w_tick) begin
        w_rx_cnt = r_rx_cnt + 1'b1;
        if (r_rx_cnt == HalfM1) begin
          w_rx_st  = w_rxs ? IDLE : DATA;
          w_rx_cnt = '0;
          w_rx_bit = '0;
        end
      end
      DATA: if (w_tick) begin
        w_rx_cnt = r_rx_cnt + 1'b1;
        if (r_rx_cnt == OsM1) begin
          w_rx_cnt = '0;
          w_rx_sh  = DataLength'({w_rxs, r_rx_sh} >> 1);
          w_rx_bit = r_rx_bit + 1'b1;
          w_rx_st  = r_rx_bit == LastBit ? STOP : DATA;
        end
      end
      default: if (r_rx_brk) begin
        w_rx_st  = w_rxs ? IDLE : STOP;
        w_rx_brk = !w_rxs;
      end else if (w_tick) begin
        w_rx_cnt = r_rx_cnt + 1'b1;
        if (r_rx_cnt == OsM1) begin
          w_rx_push = w_rxs;
          w_rx_brk  = !w_rxs;
          w_rx_st   = w_rxs ? IDLE : STOP;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_rx_st  <= IDLE;
      r_rx_cnt <= '0;
      r_rx_bit <= '0;
      r_rx_sh  <= '0;
      r_rx_brk <= 1'b0;
      r_sync   <= 2'b11;
    end else begin
      r_rx_st  <= w_rx_st;
      r_rx_cnt <= w_rx_cnt;
      r_rx_bit <= w_rx_bit;
      r_rx_sh  <= w_rx_sh;
      r_rx_brk <= w_rx_brk;
      r_sync   <= {r_sync[0], i_rx};
    end

  logic r_ovr, r_ferr, r_rts;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_baud <= '0;
      r_ovr  <= 1'b0;
      r_ferr <= 1'b0;
      r_rts  <= 1'b1;
    end else begin
      r_baud <= w_tick ? '0 : r_baud + 1'b1;
      r_ovr  <= r_ovr | (w_rx_push && w_full[1] && !i_rx_req);
      r_ferr <= r_ferr | (w_rx_brk && !r_rx_brk);
      r_rts  <= FlowControl == 0 || w_fcnt[1] < CW'(FifoDepth - 1);
    end

  assign w_push   = {w_rx_push, i_tx_req && !w_full[0]};
  assign w_pop    = {i_rx_req, w_tx_pop};
  assign w_fin[0] = i_tx_data;
  assign w_fin[1] = r_rx_sh;
  assign w_unused = ^{i_ctrl, w_fcnt[0]};
  assign o_tx      = r_tx;
  assign o_tx_rdy  = !w_full[0];
  assign o_rx_rdy  = !w_empty[1];
  assign o_rx_data = w_fout[1];
  assign o_rts     = r_rts;
  assign o_status  = {w_full[0], w_empty[0], w_full[1], w_empty[1], r_ovr, r_ferr,
                      r_tx_st != IDLE, r_rx_st != IDLE};
endmodule

// File: tb/tb_uart.sv
// tb_uart: directed self-checking bench for uart; clock chosen so one bit is 32 cycles (320 ns)
`timescale 1ns/1ps
module tb_uart;
  logic       i_clk = 1'b0, i_rst_n = 1'b0, i_tx_req = 1'b0, i_rx_req = 1'b0, i_rx = 1'b1, i_cts = 1'b1;
  logic [7:0] i_ctrl = 8'hxx, i_tx_data = 8'h00;
  logic [7:0] o_status, o_rx_data;
  logic       o_rx_rdy, o_tx_rdy, o_tx, o_rts;
  int errors = 0, checks = 0;
  logic [7:0] tx_vec [8] = '{8'hA5, 8'h3C, 8'h00, 8'hFF, 8'h81, 8'h7E, 8'h12, 8'hC9};
  logic [7:0] ctx_vec [4] = '{8'h5A, 8'hC3, 8'h01, 8'h80};
  logic [7:0] crx_vec [4] = '{8'hA3, 8'h5C, 8'h0F, 8'hF0};
  logic [7:0] cts_vec [3] = '{8'h22, 8'h44, 8'h99};

  uart #(.SystemClockFreq(3_686_400)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ctrl(i_ctrl), .o_status(o_status),
    .i_tx_data(i_tx_data), .o_rx_data(o_rx_data), .i_tx_req(i_tx_req), .i_rx_req(i_rx_req),
    .o_rx_rdy(o_rx_rdy), .o_tx_rdy(o_tx_rdy), .i_rx(i_rx), .o_tx(o_tx), .i_cts(i_cts), .o_rts(o_rts));

  always #5 i_clk = ~i_clk;

  task automatic write_tx(input logic [7:0] d);
    @(negedge i_clk);
    i_tx_req  = 1'b1;
    i_tx_data = d;
    @(negedge i_clk);
    i_tx_req  = 1'b0;
  endtask

  task automatic pop_rx();
    i_rx_req = 1'b1;
    @(negedge i_clk);
    i_rx_req = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] d, input logic sp);
    i_rx = 1'b0;
    #320;
    for (int b = 0; b < 8; b++) begin
      i_rx = d[b];
      #320;
    end
    i_rx = sp;
    #320;
  endtask

  // waits for a start edge then samples every bit at its middle
  task automatic cap_tx(output logic st, output logic [7:0] d, output logic sp, output time t, output bit ok);
    ok = 1'b0; st = 1'b1; d = 8'h00; sp = 1'b0; t = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge i_clk);
      if (!o_tx) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) return;
    t = $time;
    #160 st = o_tx;
    for (int b = 0; b < 8; b++) #320 d[b] = o_tx;
    #320 sp = o_tx;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge i_clk);
    checks++; if (o_tx !== 1'b1) begin errors++; $display("FAIL rst_in_tx got=%b exp=1", o_tx); end
    checks++; if (o_status !== 8'h50) begin errors++; $display("FAIL rst_in_status got=%h exp=50", o_status); end
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);
    checks++; if (o_tx_rdy !== 1'b1) begin errors++; $display("FAIL rst_tx_rdy got=%b exp=1", o_tx_rdy); end
    checks++; if (o_rx_rdy !== 1'b0) begin errors++; $display("FAIL rst_rx_rdy got=%b exp=0", o_rx_rdy); end
    checks++; if (o_tx !== 1'b1) begin errors++; $display("FAIL rst_tx got=%b exp=1", o_tx); end
    checks++; if (o_rts !== 1'b1) begin errors++; $display("FAIL rst_rts got=%b exp=1", o_rts); end
    checks++; if (o_status !== 8'h50) begin errors++; $display("FAIL rst_status got=%h exp=50", o_status); end
    checks++; if (o_rx_data !== 8'h00) begin errors++; $display("FAIL rst_rx_data got=%h exp=00", o_rx_data); end
  endtask

  task automatic test_back_to_back();
    logic st, sp;
    logic [7:0] d;
    time t, tp;
    bit ok;
    tp = 0;
    i_cts = 1'b1;
    fork
      for (int i = 0; i < 8; i++) write_tx(tx_vec[i]);
      for (int i = 0; i < 8; i++) begin
        cap_tx(st, d, sp, t, ok);
        checks++; if (!ok) begin errors++; $display("FAIL tx_timeout frame=%0d got=none exp=start", i); end
        checks++; if (st !== 1'b0) begin errors++; $display("FAIL tx_start[%0d] got=%b exp=0", i, st); end
        checks++; if (d !== tx_vec[i]) begin errors++; $display("FAIL tx_data[%0d] got=%h exp=%h", i, d, tx_vec[i]); end
        checks++; if (sp !== 1'b1) begin errors++; $display("FAIL tx_stop[%0d] got=%b exp=1", i, sp); end
        if (i > 0) begin
          checks++; if (t - tp != 3200) begin errors++; $display("FAIL tx_gap[%0d] got=%0t exp=3200", i, t - tp); end
        end
        tp = t;
      end
    join
    repeat (200) @(negedge i_clk);
    checks++; if (o_status[1] !== 1'b0) begin errors++; $display("FAIL tx_busy_end got=%b exp=0", o_status[1]); end
    checks++; if (o_status[6] !== 1'b1) begin errors++; $display("FAIL tx_empty_end got=%b exp=1", o_status[6]); end
  endtask

  task automatic test_rx();
    #3;
    for (int i = 0; i < 8; i++) send_rx(8'h55, 1'b1);
    @(negedge i_clk);
    checks++; if (o_rx_rdy !== 1'b1) begin errors++; $display("FAIL rx_rdy got=%b exp=1", o_rx_rdy); end
    checks++; if (o_status[5] !== 1'b1) begin errors++; $display("FAIL rx_full got=%b exp=1", o_status[5]); end
    checks++; if (o_rts !== 1'b0) begin errors++; $display("FAIL rx_rts_full got=%b exp=0", o_rts); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (o_rx_data !== 8'h55) begin errors++; $display("FAIL rx_data[%0d] got=%h exp=55", i, o_rx_data); end
      pop_rx();
    end
    checks++; if (o_rx_rdy !== 1'b0) begin errors++; $display("FAIL rx_drained got=%b exp=0", o_rx_rdy); end
    checks++; if (o_rx_data !== 8'h00) begin errors++; $display("FAIL rx_empty_data got=%h exp=00", o_rx_data); end
  endtask

  task automatic test_concurrent();
    logic st, sp;
    logic [7:0] d;
    time t;
    bit ok;
    fork
      begin
        for (int i = 0; i < 4; i++) write_tx(ctx_vec[i]);
      end
      for (int i = 0; i < 4; i++) begin
        cap_tx(st, d, sp, t, ok);
        checks++; if (!ok) begin errors++; $display("FAIL cc_timeout frame=%0d got=none exp=start", i); end
        checks++; if (d !== ctx_vec[i] || st !== 1'b0 || sp !== 1'b1)
          begin errors++; $display("FAIL cc_tx[%0d] got=%b/%h/%b exp=0/%h/1", i, st, d, sp, ctx_vec[i]); end
      end
      begin
        #7;
        for (int i = 0; i < 4; i++) send_rx(crx_vec[i], 1'b1);
      end
    join
    @(negedge i_clk);
    for (int i = 0; i < 4; i++) begin
      checks++; if (o_rx_data !== crx_vec[i]) begin errors++; $display("FAIL cc_rx[%0d] got=%h exp=%h", i, o_rx_data, crx_vec[i]); end
      pop_rx();
    end
  endtask

  task automatic test_cts();
    logic st, sp;
    logic [7:0] d;
    time t;
    bit ok;
    int lows;
    lows = 0;
    i_cts = 1'b0;
    for (int i = 0; i < 3; i++) write_tx(cts_vec[i]);
    repeat (600) begin
      @(negedge i_clk);
      if (!o_tx) lows++;
    end
    checks++; if (lows != 0) begin errors++; $display("FAIL cts_hold_lows got=%0d exp=0", lows); end
    checks++; if (o_status[1] !== 1'b0) begin errors++; $display("FAIL cts_busy got=%b exp=0", o_status[1]); end
    checks++; if (o_status[6] !== 1'b0) begin errors++; $display("FAIL cts_tx_empty got=%b exp=0", o_status[6]); end
    i_cts = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cap_tx(st, d, sp, t, ok);
      checks++; if (!ok) begin errors++; $display("FAIL cts_timeout frame=%0d got=none exp=start", i); end
      checks++; if (d !== cts_vec[i] || st !== 1'b0 || sp !== 1'b1)
        begin errors++; $display("FAIL cts_tx[%0d] got=%b/%h/%b exp=0/%h/1", i, st, d, sp, cts_vec[i]); end
    end
  endtask

  task automatic test_overrun_frame_err();
    #3;
    checks++; if (o_status[3] !== 1'b0) begin errors++; $display("FAIL ovr_pre got=%b exp=0", o_status[3]); end
    for (int k = 1; k <= 9; k++) begin
      send_rx(8'(k), 1'b1);
      @(negedge i_clk);
      if (k == 6) begin
        checks++; if (o_rts !== 1'b1) begin errors++; $display("FAIL rts_at6 got=%b exp=1", o_rts); end
      end
      if (k == 7) begin
        checks++; if (o_rts !== 1'b0) begin errors++; $display("FAIL rts_at7 got=%b exp=0", o_rts); end
      end
      if (k == 8) begin
        checks++; if (o_status[5:3] !== 3'b100) begin errors++; $display("FAIL full_at8 got=%b exp=100", o_status[5:3]); end
      end
      if (k == 9) begin
        checks++; if (o_status[5:3] !== 3'b101) begin errors++; $display("FAIL ovr_at9 got=%b exp=101", o_status[5:3]); end
      end
    end
    for (int i = 0; i < 8; i++) begin
      checks++; if (o_rx_data !== 8'(i + 1)) begin errors++; $display("FAIL ovr_data[%0d] got=%h exp=%h", i, o_rx_data, 8'(i + 1)); end
      pop_rx();
    end
    checks++; if (o_rx_rdy !== 1'b0) begin errors++; $display("FAIL ovr_ninth_dropped got=%b exp=0", o_rx_rdy); end
    #3;
    send_rx(8'h77, 1'b0);
    #320;
    @(negedge i_clk);
    checks++; if (o_status[2] !== 1'b1) begin errors++; $display("FAIL ferr_flag got=%b exp=1", o_status[2]); end
    checks++; if (o_status[0] !== 1'b1) begin errors++; $display("FAIL ferr_wait_busy got=%b exp=1", o_status[0]); end
    checks++; if (o_rx_rdy !== 1'b0) begin errors++; $display("FAIL ferr_no_push got=%b exp=0", o_rx_rdy); end
    i_rx = 1'b1;
    #640;
    @(negedge i_clk);
    checks++; if (o_status !== 8'h5C) begin errors++; $display("FAIL ferr_idle_status got=%h exp=5c", o_status); end
  endtask

  task automatic test_reset_midframe();
    bit seen;
    int lows;
    seen = 1'b0;
    lows = 0;
    i_cts = 1'b1;
    write_tx(8'h0F);
    for (int k = 0; k < 500; k++) begin
      @(negedge i_clk);
      if (!o_tx) begin
        seen = 1'b1;
        break;
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL mid_start got=none exp=start"); end
    #100;
    i_rst_n = 1'b0;
    #1;
    checks++; if (o_tx !== 1'b1) begin errors++; $display("FAIL mid_rst_tx got=%b exp=1", o_tx); end
    checks++; if (o_status !== 8'h50) begin errors++; $display("FAIL mid_rst_status got=%h exp=50", o_status); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (400) begin
      @(negedge i_clk);
      if (!o_tx) lows++;
    end
    checks++; if (lows != 0) begin errors++; $display("FAIL mid_discard_lows got=%0d exp=0", lows); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_rx();
    test_concurrent();
    test_cts();
    test_overrun_frame_err();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
